// File: rtl/nfive32_pkg.sv
// rtl/nfive32_pkg.sv - shared widths, entry type and constants for the NfiVe32 writeback stage
package nfive32_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/nfive32_wb_slot.sv
// rtl/nfive32_wb_slot.sv - one-entry result holding slot with valid/ready handshake and x0 drop
module nfive32_wb_slot
  import nfive32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            grant,
  output logic            in_ready,
  output logic            loaded,
  output wb_entry_t       entry
);

  wb_entry_t entry_q;
  wb_entry_t entry_d;

  // Ready comes from state and grant only, so it never waits on in_valid.
  assign in_ready = !entry_q.valid || grant;
  assign loaded   = in_valid && in_ready && (in_rd != REG_ZERO);
  assign entry    = entry_q;

  always_comb begin
    entry_d = entry_q;
    if (loaded) begin
      entry_d.valid = 1'b1;
      entry_d.rd    = in_rd;
      entry_d.data  = in_data;
    end else if (grant) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/nfive32_rf_writeback.sv
// rtl/nfive32_rf_writeback.sv - merges ALU and load results onto the register file write port
module nfive32_rf_writeback
  import nfive32_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [AW-1:0]   RA,
  input  logic [AW-1:0]   RB,
  output logic            haz_a,
  output logic            haz_b,
  output logic            WR,
  output logic [AW-1:0]   RW,
  output logic [XLEN-1:0] DW
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  wb_entry_t alu_e, ld_e;
  logic alu_loaded, ld_loaded;
  logic grant_alu, grant_ld;

  logic            ld_older_q, ld_older_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [XLEN-1:0] dw_q, dw_d;

  nfive32_wb_slot u_alu_slot (
    .clk      (HCLK),
    .rst      (HRESET),
    .in_valid (alu_valid),
    .in_rd    (alu_rd),
    .in_data  (alu_data),
    .grant    (grant_alu),
    .in_ready (alu_ready),
    .loaded   (alu_loaded),
    .entry    (alu_e)
  );

  nfive32_wb_slot u_ld_slot (
    .clk      (HCLK),
    .rst      (HRESET),
    .in_valid (ld_valid),
    .in_rd    (ld_rd),
    .in_data  (ld_data),
    .grant    (grant_ld),
    .in_ready (ld_ready),
    .loaded   (ld_loaded),
    .entry    (ld_e)
  );

  // Same destination: older wins to keep WAW order; otherwise load first unless the ALU is starved.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_e.valid && ld_e.valid) begin
      if (alu_e.rd == ld_e.rd) begin
        grant_ld  = ld_older_q;
        grant_alu = !ld_older_q;
      end else if (starve_q == STARVE_LIM) begin
        grant_alu = 1'b1;
      end else begin
        grant_ld = 1'b1;
      end
    end else begin
      grant_alu = alu_e.valid;
      grant_ld  = ld_e.valid;
    end
  end

  // A slot that survives the edge is older than one refilled on it.
  always_comb begin
    ld_older_d = ld_older_q;
    if (alu_loaded && ld_loaded) begin
      ld_older_d = 1'b1;
    end else if (alu_loaded && ld_e.valid && !grant_ld) begin
      ld_older_d = 1'b1;
    end else if (ld_loaded && alu_e.valid && !grant_alu) begin
      ld_older_d = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!alu_e.valid || grant_alu) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_comb begin
    wr_d = grant_alu || grant_ld;
    rw_d = rw_q;
    dw_d = dw_q;
    if (grant_alu) begin
      rw_d = alu_e.rd;
      dw_d = alu_e.data;
    end else if (grant_ld) begin
      rw_d = ld_e.rd;
      dw_d = ld_e.data;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ld_older_q <= 1'b0;
      starve_q   <= '0;
      wr_q       <= 1'b0;
      rw_q       <= '0;
      dw_q       <= '0;
    end else begin
      ld_older_q <= ld_older_d;
      starve_q   <= starve_d;
      wr_q       <= wr_d;
      rw_q       <= rw_d;
      dw_q       <= dw_d;
    end
  end

  assign WR = wr_q;
  assign RW = rw_q;
  assign DW = dw_q;

  // The registered write term covers the cycle before the RF commits.
  assign haz_a = (RA != REG_ZERO) &&
                 ((alu_e.valid && alu_e.rd == RA) || (ld_e.valid && ld_e.rd == RA) || (wr_q && rw_q == RA));
  assign haz_b = (RB != REG_ZERO) &&
                 ((alu_e.valid && alu_e.rd == RB) || (ld_e.valid && ld_e.rd == RB) || (wr_q && rw_q == RB));

endmodule

// File: tb/tb_nfive32_rf_writeback.sv
// tb/tb_nfive32_rf_writeback.sv - randomized and directed bench for nfive32_rf_writeback
module tb_nfive32_rf_writeback;
  import nfive32_pkg::*;

  localparam int SMAX = 3;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            alu_valid, alu_ready, ld_valid, ld_ready;
  logic [AW-1:0]   alu_rd, ld_rd, RA, RB, RW;
  logic [XLEN-1:0] alu_data, ld_data, DW;
  logic            haz_a, haz_b, WR;

  always #5 HCLK = ~HCLK;

  nfive32_rf_writeback #(.STARVE_MAX(SMAX)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .RA(RA), .RB(RB), .haz_a(haz_a), .haz_b(haz_b),
    .WR(WR), .RW(RW), .DW(DW)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: index 0 = ALU, 1 = load; age kept as arrival sequence numbers.
  bit              mv[2];
  logic [AW-1:0]   mrd[2];
  logic [XLEN-1:0] mdat[2];
  int              mseq[2];
  int              seq_n, starve;
  bit              ewr;
  logic [AW-1:0]   erw;
  logic [XLEN-1:0] edw;
  logic [AW-1:0]   wq_rd[$];
  logic [XLEN-1:0] wq_dat[$];
  bit              a_fire, l_fire;

  function automatic bit mhaz(input logic [AW-1:0] r);
    return (r != 0) && ((mv[0] && mrd[0] == r) || (mv[1] && mrd[1] == r) || (ewr && erw == r));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0;
      mseq[i] = 0;
    end
    seq_n = 0;
    starve = 0;
    ewr = 1'b0;
    erw = '0;
    edw = '0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic step();
    int g;
    bit rdy0, rdy1;
    #1;
    g = -1;
    if (mv[0] && mv[1]) begin
      if (mrd[0] == mrd[1]) g = (mseq[0] < mseq[1]) ? 0 : 1;
      else                  g = (starve == SMAX) ? 0 : 1;
    end else if (mv[0]) g = 0;
    else if (mv[1])     g = 1;
    rdy0 = !mv[0] || g == 0;
    rdy1 = !mv[1] || g == 1;
    check("alu_ready", alu_ready, rdy0);
    check("ld_ready", ld_ready, rdy1);
    check("haz_a", haz_a, mhaz(RA));
    check("haz_b", haz_b, mhaz(RB));
    a_fire = alu_valid && rdy0;
    l_fire = ld_valid && rdy1;
    @(posedge HCLK);
    #1;
    ewr = (g >= 0);
    if (g >= 0) begin
      erw = mrd[g];
      edw = mdat[g];
    end
    if (mv[0] && g != 0) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else                 starve = 0;
    if (g >= 0) mv[g] = 1'b0;
    if (l_fire && ld_rd != 0) begin
      mv[1] = 1'b1; mrd[1] = ld_rd; mdat[1] = ld_data; mseq[1] = seq_n;
    end
    if (a_fire && alu_rd != 0) begin
      mv[0] = 1'b1; mrd[0] = alu_rd; mdat[0] = alu_data; mseq[0] = seq_n + 1;
    end
    seq_n += 2;
    check("WR", WR, ewr);
    check("RW", RW, erw);
    check("DW", DW, edw);
    if (WR) begin
      wq_rd.push_back(RW);
      wq_dat.push_back(DW);
    end
  endtask

  int base, k, idx;

  initial begin
    idle_inputs();
    RA = 5'd3; RB = 5'd4;
    model_reset();
    #12;
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_WR", WR, 0);
    check("rst_RW", RW, 0);
    check("rst_DW", DW, 0);
    check("rst_haz_a", haz_a, 0);
    HRESET = 1'b0;

    // Single ALU write with hazard on RA
    RA = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h64;
    step();
    idle_inputs();
    step();
    check("single_WR", WR, 1);
    check("single_RW", RW, 5);
    check("single_DW", DW, 32'h64);
    step();
    step();
    check("single_haz_clear", haz_a, 0);

    // Simultaneous load and ALU: load first
    base = wq_rd.size();
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hC8;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h3E7;
    step();
    idle_inputs();
    repeat (3) step();
    check("simul_first", wq_rd[base], 10);
    check("simul_second", wq_rd[base + 1], 20);

    // WAW on rd 7: ALU accepted a cycle before the load
    base = wq_rd.size();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
    step();
    alu_valid = 1'b0;
    ld_rd = 5'd7; ld_data = 32'h2;
    step();
    idle_inputs();
    repeat (4) step();
    check("waw_first", wq_dat[base + 1], 32'h1);
    check("waw_second", wq_dat[base + 2], 32'h2);

    // Starvation: ALU rd 9 against a continuous load stream
    base = wq_rd.size();
    k = 1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_rd = AW'(k); ld_data = 32'h100 + k;
      step();
      if (a_fire) alu_valid = 1'b0;
      if (l_fire) k++;
    end
    idle_inputs();
    repeat (3) step();
    idx = -1;
    for (int i = base; i < wq_rd.size(); i++)
      if (idx < 0 && wq_rd[i] == 9) idx = i - base;
    check("starve_pos", idx, 3);

    // x0 drop
    RA = '0; RB = '0;
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h383;
    step();
    check("x0_accept", a_fire, 1);
    idle_inputs();
    step();
    check("x0_WR", WR, 0);
    check("x0_haz", {haz_a, haz_b}, 0);

    // Reset mid-stream with both slots full
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'hB;
    RA = 5'd3; RB = 5'd4;
    step();
    idle_inputs();
    HRESET = 1'b1;
    #1;
    check("mid_rst_alu_ready", alu_ready, 1);
    check("mid_rst_ld_ready", ld_ready, 1);
    check("mid_rst_WR", WR, 0);
    check("mid_rst_RW", RW, 0);
    check("mid_rst_DW", DW, 0);
    model_reset();
    HRESET = 1'b0;
    #1;
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      alu_valid = ($urandom_range(0, 9) < 6);
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 6);
      ld_rd     = AW'($urandom_range(0, 7));
      ld_data   = $urandom;
      RA        = AW'($urandom_range(0, 7));
      RB        = AW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nfive32_rf_writeback.md
Name: nfive32_rf_writeback

Overview:
- Writeback stage directly upstream of the NfiVe32 register file; drives the RF single write port (WR/RW/DW).
- Merges two result producers, the ALU and the load unit, each with a valid/ready handshake and a one-entry holding slot.
- Arbitrates the producers onto the write port with registered outputs.
- Reports read-after-write hazards for the decode-stage read addresses RA/RB so decode can stall.

Parameters:
- XLEN, 32, data width of results and DW.
- AW, 5, register address width (32 registers).
- STARVE_MAX, 3, consecutive ALU arbitration losses before the ALU is forced to win (must be ≥1).

Ports:
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  writeback can accept an ALU result.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  writeback can accept a load result.
- ld_rd  in  AW  load destination register.
- ld_data  in  XLEN  load result.
- RA  in  AW  decode read address A (same value presented to the RF).
- RB  in  AW  decode read address B.
- haz_a  out  1  RA has a write pending in this block.
- haz_b  out  1  RB has a write pending in this block.
- WR  out  1  RF write enable, registered.
- RW  out  AW  RF write address, registered.
- DW  out  XLEN  RF write data, registered.

Behaviour:
- Reset (async, HRESET=1): both slots empty, age bit 0, starvation counter 0, WR=0, RW=0, DW=0. Since the slots are empty, alu_ready=ld_ready=1 and haz_a=haz_b=0. A reset mid-operation discards all pending entries; nothing is written.
- Slot: {valid, rd, data} per channel.
  - Handshake fires when x_valid && x_ready at a rising edge.
  - x_ready = !slot_valid || slot is granted this cycle (combinational from state only; never depends on x_valid).
- rd==0 handling: a handshake with rd==0 is accepted and dropped. The slot is not loaded, and no write is ever issued to x0.
- Age bit: records which slot was loaded first when both are valid. Simultaneous acceptance into both empty slots marks the load slot as older.
- Arbitration (combinational, among valid slots):
  - Only one slot valid: that slot wins.
  - Both valid with equal rd: the older slot wins, preserving program-order WAW.
  - Both valid with different rd: the load slot wins, unless the starvation counter equals STARVE_MAX, in which case the ALU wins.
- Starvation counter:
  - Increments when the ALU slot is valid and loses.
  - Clears when the ALU wins or when the ALU slot is empty.
  - Saturates at STARVE_MAX.
- Write port: at the edge after a grant, WR<=1, RW<=rd, DW<=data.
  - With no grant, WR<=0 and RW/DW hold their previous values.
  - Latency: a handshake at edge N into an empty slot gives a grant during cycle N→N+1 at the earliest, and WR=1 after edge N+1.
- Drain and refill: a granted slot clears at the edge unless the same channel handshakes on that edge, in which case it reloads with the new entry. Throughput is one write per cycle sustained.
- Hazards:
  - haz_a = (RA!=0) && (RA matches a valid slot rd, or (WR && RW==RA)).
  - haz_b is identical using RB.
  - The WR term covers the cycle before the RF commits the write.
- Data and addresses pass unmodified; no arithmetic beyond the counter.

Decomposition:
- Package nfive32_pkg:
  - Constants XLEN and AW.
  - typedef wb_entry_t {logic valid; logic [AW-1:0] rd; logic [XLEN-1:0] data}.
  - Constant REG_ZERO = 0.
- Sub-module nfive32_wb_slot:
  - One-entry holding register with valid/ready handshake, x0 drop, grant/clear input, and entry output.
  - Instantiated twice (ALU, load).
- Arbitration, age bit, starvation counter, output registers and hazard compare stay in the top module.

Test Plan:
- Reset with HRESET pulsed mid-stream while both slots are full -> WR=0, RW=0, DW=0, alu_ready=ld_ready=1 immediately, and no later write of the discarded entries.
- Single ALU write: alu_rd=5, alu_data=0x64 for one cycle -> WR=1, RW=5, DW=0x64 exactly one cycle after the grant; haz_a=1 while RA=5 until WR drops.
- Simultaneous load rd=10/0xC8 and ALU rd=20/0x3E7 -> load written first, ALU on the next cycle; ld_ready and alu_ready behave per the refill rule.
- WAW ordering: ALU rd=7/0x1 accepted one cycle before load rd=7/0x2 -> RF writes 0x1 then 0x2, despite load priority.
- Starvation with STARVE_MAX=3: continuous load stream to rd=1..N plus one pending ALU rd=9 -> the ALU write appears after exactly 3 load writes.
- x0 drop: alu_rd=0, data 0x383 -> handshake completes, WR stays 0, haz_a=haz_b=0 with RA=RB=0.
